dmem_responder: RTL

Data-memory responder for the RISC-V pipeline's memory stage. It accepts one load or store request at a time over a valid/ready handshake and performs byte, halfword or word accesses on an internal little-endian word array. It returns a response, with read data or an error flag, after a fixed latency over a second valid/ready handshake. It replaces the single-cycle data memory so that multi-cycle memory timing and stall paths can be exercised.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-stage types: access-size encodings, responder FSM states, request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  // Request fields captured at accept.
  typedef struct packed {
    logic                we;
    mem_size_e           size;
    logic                is_unsigned;
    logic [XLEN_DEF-1:0] addr;
    logic [XLEN_DEF-1:0] wdata;
  } mem_req_t;

  function automatic logic size_illegal(input mem_size_e s);
    return (s == MEM_ILL);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a little-endian 32-bit word: write mask/data and load extraction.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: addr_lo/size/load_unsigned/wdata/rdata_word in; byte_mask, wdata_lane,
//        load_data, misalign out. Illegal size yields an empty mask and is flagged by the caller.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]          addr_lo,
  input  mem_size_e           size,
  input  logic                load_unsigned,
  input  logic [XLEN_DEF-1:0] wdata,
  input  logic [XLEN_DEF-1:0] rdata_word,
  output logic [3:0]          byte_mask,
  output logic [XLEN_DEF-1:0] wdata_lane,
  output logic [XLEN_DEF-1:0] load_data,
  output logic                misalign
);

  logic [XLEN_DEF-1:0] shifted;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;

  // Bring the addressed lane(s) down to bit 0 before extension.
  assign shifted  = rdata_word >> {addr_lo, 3'b000};
  assign sel_byte = shifted[7:0];
  assign sel_half = shifted[15:0];

  always_comb begin
    byte_mask  = 4'b0000;
    wdata_lane = '0;
    load_data  = '0;
    misalign   = 1'b0;
    case (size)
      MEM_BYTE: begin
        byte_mask  = 4'b0001 << addr_lo;
        // Replicating the low byte puts wdata byte 0 on whichever lane the mask enables.
        wdata_lane = {4{wdata[7:0]}};
        load_data  = load_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      MEM_HALF: begin
        byte_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        load_data  = load_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
        misalign   = addr_lo[0];
      end
      MEM_WORD: begin
        byte_mask  = 4'b1111;
        wdata_lane = wdata;
        load_data  = rdata_word;
        misalign   = |addr_lo;
      end
      default: begin
        byte_mask = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time on a little-endian word array.
// Latency: resp_valid rises LATENCY cycles after request accept; array access on that edge.
// Backpressure: req_ready low while busy; response held stable until resp_ready.
// Ports: clk/rst (async active-low); req_* request handshake and fields;
//        resp_* response handshake, data and fault flag; busy = request outstanding.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic DIRECT_RESP = (LATENCY == 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  dmem_state_e     state_q, state_d;
  logic            alive_q, alive_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mem_req_t        req_q, req_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  mem_req_t        live_req;
  mem_req_t        cur_req;
  logic [AW-1:0]   word_idx;
  logic            out_of_range;
  logic            fault;
  logic            accept;
  logic            enter_resp;
  logic            mem_we;
  logic [XLEN-1:0] rd_word;
  logic [3:0]      byte_mask;
  logic [XLEN-1:0] wdata_lane;
  logic [XLEN-1:0] load_data;
  logic            misalign;

  assign live_req = '{we: req_we, size: mem_size_e'(req_size), is_unsigned: req_unsigned,
                      addr: req_addr, wdata: req_wdata};

  // With LATENCY==1 the access happens on the accept edge itself, so the live
  // inputs must feed the datapath while idle; otherwise the captured copy does.
  assign cur_req = (state_q == ST_IDLE) ? live_req : req_q;

  assign word_idx     = cur_req.addr[AW+1:2];
  assign out_of_range = |cur_req.addr[XLEN-1:AW+2];
  assign rd_word      = mem_q[word_idx];

  dmem_lane_align u_align (
    .addr_lo       (cur_req.addr[1:0]),
    .size          (cur_req.size),
    .load_unsigned (cur_req.is_unsigned),
    .wdata         (cur_req.wdata),
    .rdata_word    (rd_word),
    .byte_mask     (byte_mask),
    .wdata_lane    (wdata_lane),
    .load_data     (load_data),
    .misalign      (misalign)
  );

  assign fault = size_illegal(cur_req.size) | misalign | out_of_range;

  // alive_q keeps req_ready low until the first edge after reset release.
  assign req_ready  = alive_q && (state_q == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    alive_d      = 1'b1;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    enter_resp   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = live_req;
          cnt_d = CNT_LOAD;
          if (DIRECT_RESP) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Counter runs down one per cycle; the edge after it hits zero enters RESP,
        // which lands resp_valid exactly LATENCY edges after accept.
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_resp) begin
      resp_err_d   = fault;
      resp_rdata_d = (fault || cur_req.we) ? '0 : load_data;
    end
  end

  assign mem_we = enter_resp && cur_req.we && !fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      alive_q      <= 1'b0;
      cnt_q        <= '0;
      req_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array has no reset; writes only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_mask[k]) begin
          mem_q[word_idx][8*k +: 8] <= wdata_lane[8*k +: 8];
        end
      end
    end
  end

endmodule
